// File: rtl/comp_rx_packer_if.sv
// comp_rx_packer_if: control, sample and FIFO read-side bundle for comp_rx_packer.
// Ports: ENABLE, SAMPLE_STB, COMP_OUT[NCH], FLUSH, CLEAR_CNT, FIFO_READ_NEXT (to packer);
//        FIFO_DATA_OUT[WORD_WIDTH], FIFO_EMPTY, FIFO_FULL, OVERFLOW_CNT[16], BUSY (from packer).
interface comp_rx_packer_if #(
    parameter int NCH        = 4,
    parameter int WORD_WIDTH = 32
);
    logic                  ENABLE;
    logic                  SAMPLE_STB;
    logic [NCH-1:0]        COMP_OUT;
    logic                  FLUSH;
    logic                  CLEAR_CNT;
    logic [WORD_WIDTH-1:0] FIFO_DATA_OUT;
    logic                  FIFO_READ_NEXT;
    logic                  FIFO_EMPTY;
    logic                  FIFO_FULL;
    logic [15:0]           OVERFLOW_CNT;
    logic                  BUSY;

    modport master (
        output ENABLE, SAMPLE_STB, COMP_OUT, FLUSH, CLEAR_CNT, FIFO_READ_NEXT,
        input  FIFO_DATA_OUT, FIFO_EMPTY, FIFO_FULL, OVERFLOW_CNT, BUSY
    );

    modport slave (
        input  ENABLE, SAMPLE_STB, COMP_OUT, FLUSH, CLEAR_CNT, FIFO_READ_NEXT,
        output FIFO_DATA_OUT, FIFO_EMPTY, FIFO_FULL, OVERFLOW_CNT, BUSY
    );
endinterface

// File: rtl/comp_rx_packer.sv
// comp_rx_packer: packs NCH comparator bit streams into tagged words and queues them in a shared show-ahead FIFO.
// Ports: SEQ_CLK (clock), RST_B (async active-low reset), bus (comp_rx_packer_if.slave: sample/flush/clear
//        controls in, FIFO head word, empty/full flags, saturating overflow count and BUSY out).
// Word layout: [WW-1:WW-4] channel id, [WW-5:WW-10] nbits, [WW-11:0] MSB-first left-aligned payload.
module comp_rx_packer #(
    parameter int NCH        = 4,
    parameter int WORD_WIDTH = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic             SEQ_CLK,
    input  logic             RST_B,
    comp_rx_packer_if.slave  bus
);
    localparam int PAYLOAD_W = WORD_WIDTH - 10;
    localparam int AW        = $clog2(FIFO_DEPTH);
    localparam int RW        = NCH > 1 ? $clog2(NCH) : 1;

    logic [PAYLOAD_W-1:0]  acc_q  [NCH];
    logic [PAYLOAD_W-1:0]  acc_d  [NCH];
    logic [5:0]            cnt_q  [NCH];
    logic [5:0]            cnt_d  [NCH];
    logic [WORD_WIDTH-1:0] slot_q [NCH];
    logic [WORD_WIDTH-1:0] slot_d [NCH];
    logic [NCH-1:0]        slot_v_q, slot_v_d;
    logic [RW-1:0]         rr_q, rr_d;
    logic [15:0]           ovf_q, ovf_d;
    logic [WORD_WIDTH-1:0] mem_q  [FIFO_DEPTH];
    logic [AW:0]           wr_q, rd_q;

    logic                  stb, empty, full, pop, any_cnt;
    logic                  gnt_v;
    logic [RW-1:0]         gnt;
    logic [NCH-1:0]        gnt_oh, rot;
    logic [2*NCH-1:0]      dbl;
    logic [16:0]           drops, ovf_sum;

    assign stb   = bus.SAMPLE_STB & bus.ENABLE;
    assign empty = wr_q == rd_q;
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop   = bus.FIFO_READ_NEXT & ~empty;

    // Rotate the occupancy vector so bit 0 is the slot at rr_q; the lowest set bit wins.
    always_comb begin
        dbl   = {slot_v_q, slot_v_q} >> rr_q;
        rot   = dbl[NCH-1:0];
        gnt   = '0;
        gnt_v = |rot & ~full;
        for (int o = NCH - 1; o >= 0; o--)
            if (rot[o]) gnt = RW'((int'(rr_q) + o) % NCH);
        gnt_oh = gnt_v ? (NCH'(1) << gnt) : '0;
        rr_d   = gnt_v ? RW'((int'(gnt) + 1) % NCH) : rr_q;
    end

    // Per-channel accumulate, close and slot load; a closing word is lost only if its slot stays occupied.
    always_comb begin
        logic [PAYLOAD_W-1:0]  acc_s;
        logic [5:0]            cnt_s;
        logic                  close;
        drops   = '0;
        any_cnt = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            acc_s = stb ? acc_q[i] | ({bus.COMP_OUT[i], {(PAYLOAD_W-1){1'b0}}} >> cnt_q[i]) : acc_q[i];
            cnt_s = stb ? cnt_q[i] + 6'd1 : cnt_q[i];
            close = (cnt_s == 6'(PAYLOAD_W)) || (bus.FLUSH && cnt_s != '0);
            acc_d[i]    = close ? '0 : acc_s;
            cnt_d[i]    = close ? '0 : cnt_s;
            slot_d[i]   = slot_q[i];
            slot_v_d[i] = slot_v_q[i] & ~gnt_oh[i];
            if (close && slot_v_q[i] && !gnt_oh[i]) begin
                drops = drops + 17'd1;
            end else if (close) begin
                slot_d[i]   = {4'(i), cnt_s, acc_s};
                slot_v_d[i] = 1'b1;
            end
            any_cnt = any_cnt | (cnt_q[i] != '0);
        end
        ovf_sum = {1'b0, ovf_q} + drops;
        ovf_d   = bus.CLEAR_CNT ? '0 : (ovf_sum > 17'hFFFF) ? 16'hFFFF : ovf_sum[15:0];
    end

    always_ff @(posedge SEQ_CLK or negedge RST_B) begin
        if (!RST_B) begin
            for (int i = 0; i < NCH; i++) begin
                acc_q[i]  <= '0;
                cnt_q[i]  <= '0;
                slot_q[i] <= '0;
            end
            slot_v_q <= '0;
            rr_q     <= '0;
            ovf_q    <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                acc_q[i]  <= acc_d[i];
                cnt_q[i]  <= cnt_d[i];
                slot_q[i] <= slot_d[i];
            end
            slot_v_q <= slot_v_d;
            rr_q     <= rr_d;
            ovf_q    <= ovf_d;
            wr_q     <= wr_q + (AW+1)'(gnt_v);
            rd_q     <= rd_q + (AW+1)'(pop);
        end
    end

    // Storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge SEQ_CLK)
        if (gnt_v) mem_q[wr_q[AW-1:0]] <= slot_q[gnt];

    assign bus.FIFO_DATA_OUT = empty ? '0 : mem_q[rd_q[AW-1:0]];
    assign bus.FIFO_EMPTY    = empty;
    assign bus.FIFO_FULL     = full;
    assign bus.OVERFLOW_CNT  = ovf_q;
    assign bus.BUSY          = any_cnt | (|slot_v_q) | ~empty;
endmodule

// File: tb/tb_comp_rx_packer.sv
// tb_comp_rx_packer: directed self-checking bench for comp_rx_packer with default parameters.
module tb_comp_rx_packer;
    logic SEQ_CLK = 1'b0;
    logic RST_B   = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    comp_rx_packer_if #(.NCH(4), .WORD_WIDTH(32)) bus ();
    comp_rx_packer #(.NCH(4), .WORD_WIDTH(32), .FIFO_DEPTH(16)) dut (
        .SEQ_CLK (SEQ_CLK),
        .RST_B   (RST_B),
        .bus     (bus)
    );

    always #5 SEQ_CLK = ~SEQ_CLK;

    function automatic logic [31:0] w(input int ch, input int n, input logic [21:0] p);
        return {4'(ch), 6'(n), p};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge SEQ_CLK);
        #1;
    endtask

    task automatic strobe(input logic [3:0] v);
        bus.SAMPLE_STB = 1'b1;
        bus.COMP_OUT   = v;
        tick();
        bus.SAMPLE_STB = 1'b0;
        bus.COMP_OUT   = '0;
    endtask

    task automatic flush();
        bus.FLUSH = 1'b1;
        tick();
        bus.FLUSH = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] exp);
        chk(tag, 64'(bus.FIFO_DATA_OUT), 64'(exp));
        bus.FIFO_READ_NEXT = 1'b1;
        tick();
        bus.FIFO_READ_NEXT = 1'b0;
    endtask

    initial begin
        bus.ENABLE = 0; bus.SAMPLE_STB = 0; bus.COMP_OUT = '0; bus.FLUSH = 0;
        bus.CLEAR_CNT = 0; bus.FIFO_READ_NEXT = 0;
        tick(); tick();
        chk("rst_empty", 64'(bus.FIFO_EMPTY), 1);
        chk("rst_full", 64'(bus.FIFO_FULL), 0);
        chk("rst_busy", 64'(bus.BUSY), 0);
        chk("rst_data", 64'(bus.FIFO_DATA_OUT), 0);
        chk("rst_ovf", 64'(bus.OVERFLOW_CNT), 0);
        RST_B = 1'b1;
        tick();

        // 22 strobes, ch0 alternating starting with 1
        bus.ENABLE = 1'b1;
        for (int i = 0; i < 22; i++) strobe({3'b000, i % 2 == 0});
        chk("t1_empty_at_close", 64'(bus.FIFO_EMPTY), 1);
        chk("t1_busy", 64'(bus.BUSY), 1);
        tick();
        chk("t1_empty_after", 64'(bus.FIFO_EMPTY), 0);
        chk("t1_head", 64'(bus.FIFO_DATA_OUT), 64'(w(0, 22, 22'h2AAAAA)));
        repeat (3) tick();
        pop_chk("t1_w0", w(0, 22, 22'h2AAAAA));
        pop_chk("t1_w1", w(1, 22, 0));
        pop_chk("t1_w2", w(2, 22, 0));
        pop_chk("t1_w3", w(3, 22, 0));
        chk("t1_drained", 64'(bus.FIFO_EMPTY), 1);
        chk("t1_idle", 64'(bus.BUSY), 0);

        // 5 strobes ch2=1 then flush
        for (int i = 0; i < 5; i++) strobe(4'b0100);
        flush();
        repeat (5) tick();
        pop_chk("t2_w0", w(0, 5, 0));
        pop_chk("t2_w1", w(1, 5, 0));
        pop_chk("t2_w2", w(2, 5, 22'h3E0000));
        pop_chk("t2_w3", w(3, 5, 0));
        flush();
        repeat (3) tick();
        chk("t2_second_flush_empty", 64'(bus.FIFO_EMPTY), 1);
        chk("t2_second_flush_busy", 64'(bus.BUSY), 0);

        // fill FIFO, fill slots, then drop
        for (int i = 0; i < 88; i++) strobe(4'h0);
        repeat (4) tick();
        chk("t3_full", 64'(bus.FIFO_FULL), 1);
        chk("t3_ovf0", 64'(bus.OVERFLOW_CNT), 0);
        for (int i = 0; i < 22; i++) strobe(4'hF);
        repeat (2) tick();
        chk("t3_pending_ovf", 64'(bus.OVERFLOW_CNT), 0);
        chk("t3_pending_busy", 64'(bus.BUSY), 1);
        for (int i = 0; i < 22; i++) strobe(4'h0);
        chk("t3_ovf4", 64'(bus.OVERFLOW_CNT), 4);
        bus.CLEAR_CNT = 1'b1;
        tick();
        bus.CLEAR_CNT = 1'b0;
        chk("t3_clear", 64'(bus.OVERFLOW_CNT), 0);

        // one pop frees one place, next edge refills from rr position
        pop_chk("t4_w0", w(0, 22, 0));
        chk("t4_not_full", 64'(bus.FIFO_FULL), 0);
        tick();
        chk("t4_refull", 64'(bus.FIFO_FULL), 1);
        for (int k = 1; k < 20; k++)
            pop_chk($sformatf("t4_w%0d", k), w(k % 4, 22, k < 16 ? 22'h0 : 22'h3FFFFF));
        tick();
        chk("t4_drained", 64'(bus.FIFO_EMPTY), 1);
        chk("t4_idle", 64'(bus.BUSY), 0);

        // strobe and flush together at the 22nd sample
        for (int i = 0; i < 21; i++) strobe(4'b0001);
        bus.FLUSH = 1'b1;
        strobe(4'b0001);
        bus.FLUSH = 1'b0;
        repeat (4) tick();
        pop_chk("t5_w0", w(0, 22, 22'h3FFFFF));
        pop_chk("t5_w1", w(1, 22, 0));
        pop_chk("t5_w2", w(2, 22, 0));
        pop_chk("t5_w3", w(3, 22, 0));
        tick();
        chk("t5_no_extra", 64'(bus.FIFO_EMPTY), 1);
        bus.ENABLE = 1'b0;
        for (int i = 0; i < 5; i++) strobe(4'hF);
        flush();
        repeat (3) tick();
        chk("t5_disabled_empty", 64'(bus.FIFO_EMPTY), 1);
        chk("t5_disabled_busy", 64'(bus.BUSY), 0);
        bus.ENABLE = 1'b1;

        // async reset with count=10 and 3 words queued
        for (int i = 0; i < 32; i++) strobe(4'h0);
        pop_chk("t6_w0", w(0, 22, 0));
        chk("t6_busy_pre", 64'(bus.BUSY), 1);
        #2 RST_B = 1'b0;
        #1;
        chk("t6_rst_empty", 64'(bus.FIFO_EMPTY), 1);
        chk("t6_rst_full", 64'(bus.FIFO_FULL), 0);
        chk("t6_rst_busy", 64'(bus.BUSY), 0);
        chk("t6_rst_data", 64'(bus.FIFO_DATA_OUT), 0);
        #3 RST_B = 1'b1;
        tick();
        for (int i = 0; i < 21; i++) strobe(4'b1000);
        repeat (2) tick();
        chk("t6_fresh_count", 64'(bus.FIFO_EMPTY), 1);
        strobe(4'b1000);
        tick();
        pop_chk("t6_n0", w(0, 22, 0));
        tick();
        pop_chk("t6_n1", w(1, 22, 0));
        pop_chk("t6_n2", w(2, 22, 0));
        pop_chk("t6_n3", w(3, 22, 22'h3FFFFF));
        chk("t6_drained", 64'(bus.FIFO_EMPTY), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
